// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd issue/retire stage.
package fpadd_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 5;

    localparam logic [RM_W-1:0] RM_RNE = 3'b000;
    localparam logic [RM_W-1:0] RM_RD  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;

    // One queued add request (134 bits)
    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [RM_W-1:0]   rm;
        logic [OP_W-1:0]   op_type;
    } fpadd_req_t;

endpackage

// File: rtl/fpadd_req_fifo.sv
// First-word-fall-through synchronous FIFO of fpadd requests; reads as zero when empty.
module fpadd_req_fifo
    import fpadd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  fpadd_req_t wdata,
    input  logic       pop,
    output fpadd_req_t rdata_c,
    output logic       full_c,
    output logic       empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fpadd_req_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign push_ok = push && !full_c;
    assign pop_ok  = pop && !empty_c;
    assign rdata_c = empty_c ? '0 : mem[rd_ptr];

    // Storage needs no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fpadd_issue_stage.sv
// Buffered issue/retire stage around an external combinational fpadd.
// Optional sticky exception summary enabled by FPADD_STICKY_FLAGS_EN.
module fpadd_issue_stage
    import fpadd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [RM_W-1:0]   in_rm,
    input  logic [OP_W-1:0]   in_op_type,
    output logic [DATA_W-1:0] fa_op1,
    output logic [DATA_W-1:0] fa_op2,
    output logic [RM_W-1:0]   fa_rm,
    output logic [OP_W-1:0]   fa_op_type,
    output logic              fa_P,
    output logic              fa_OvEn,
    output logic              fa_UnEn,
    input  logic [DATA_W-1:0] fa_result,
    input  logic [FLAG_W-1:0] fa_Flags,
    input  logic              fa_Denorm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_denorm,
    input  logic              flags_clr,
    output logic [FLAG_W-1:0] sticky_flags
);

    fpadd_req_t req_in;
    fpadd_req_t head_c;
    logic       full_c;
    logic       empty_c;
    logic       push;
    logic       retire;

    assign req_in   = '{op1: in_op1, op2: in_op2, rm: in_rm, op_type: in_op_type};
    assign in_ready = !full_c;
    assign push     = in_valid && in_ready;
    assign retire   = !empty_c && (!out_valid || out_ready);

    fpadd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wdata   (req_in),
        .pop     (retire),
        .rdata_c (head_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Empty queue presents an all-zero head, so the fpadd sees quiet operands
    assign fa_op1     = head_c.op1;
    assign fa_op2     = head_c.op2;
    assign fa_rm      = head_c.rm;
    assign fa_op_type = head_c.op_type;
    assign fa_P       = 1'b0;
    assign fa_OvEn    = 1'b0;
    assign fa_UnEn    = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_denorm <= 1'b0;
        end else if (retire) begin
            out_valid  <= 1'b1;
            out_result <= fa_result;
            out_flags  <= fa_Flags;
            out_denorm <= fa_Denorm;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef FPADD_STICKY_FLAGS_EN
    // A clear coinciding with a retire keeps only the newly retired flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_flags <= '0;
        end else if (retire) begin
            sticky_flags <= (flags_clr ? '0 : sticky_flags) | fa_Flags;
        end else if (flags_clr) begin
            sticky_flags <= '0;
        end
    end
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign sticky_flags     = '0;
`endif

endmodule

// File: tb/tb_fpadd_issue_stage.sv
// Randomized self-checking bench for fpadd_issue_stage with a behavioural fpadd stand-in.
module tb_fpadd_issue_stage;
    import fpadd_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] TINY  = 64'h3C30000000000000;

    typedef struct packed {
        logic [63:0] r;
        logic [4:0]  f;
        logic        d;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [63:0] in_op1 = '0;
    logic [63:0] in_op2 = '0;
    logic [2:0]  in_rm = '0;
    logic [2:0]  in_op_type = '0;
    logic [63:0] fa_op1, fa_op2;
    logic [2:0]  fa_rm, fa_op_type;
    logic        fa_P, fa_OvEn, fa_UnEn;
    logic [63:0] fa_result;
    logic [4:0]  fa_Flags;
    logic        fa_Denorm;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic        out_denorm;
    logic        flags_clr = 1'b0;
    logic [4:0]  sticky_flags;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   qcnt;
    bit   slot;
    res_t slot_item;
    res_t pend[$];
    logic [4:0] sticky_m;

    fpadd_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_rm(in_rm), .in_op_type(in_op_type),
        .fa_op1(fa_op1), .fa_op2(fa_op2), .fa_rm(fa_rm), .fa_op_type(fa_op_type),
        .fa_P(fa_P), .fa_OvEn(fa_OvEn), .fa_UnEn(fa_UnEn),
        .fa_result(fa_result), .fa_Flags(fa_Flags), .fa_Denorm(fa_Denorm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_denorm(out_denorm),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    // Behavioural add: real arithmetic, inexact (bit 0) when the sum loses bits
    function automatic res_t fp_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic [2:0] rm, input logic [2:0] op);
        real  ra, rb, s;
        res_t x;
        ra   = $bitstoreal(a);
        rb   = $bitstoreal(b);
        s    = ra + rb;
        x.r  = $realtobits(s);
        x.f  = '0;
        x.f[0] = ((s - ra) != rb) || ((s - rb) != ra);
        x.d  = rm[0] ^ op[0] ^ a[0];
        return x;
    endfunction

    always_comb begin
        res_t y;
        y         = fp_model(fa_op1, fa_op2, fa_rm, fa_op_type);
        fa_result = y.r;
        fa_Flags  = y.f;
        fa_Denorm = y.d;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        qcnt = 0;
        slot = 0;
        pend.delete();
        sticky_m = '0;
    endtask

    // Advance one clock; model follows the queue/slot rules and checks all outputs
    task automatic step();
        bit   push, ret, take;
        res_t nr;
        push = in_valid && (qcnt < DEPTH);
        ret  = (qcnt > 0) && (!slot || out_ready);
        take = slot && out_ready;
        nr   = fp_model(in_op1, in_op2, in_rm, in_op_type);
        @(posedge clk);
        #1;
        if (ret) begin
            slot_item = pend.pop_front();
`ifdef FPADD_STICKY_FLAGS_EN
            sticky_m = (flags_clr ? 5'b0 : sticky_m) | slot_item.f;
`endif
            slot = 1;
        end else begin
            if (take) slot = 0;
`ifdef FPADD_STICKY_FLAGS_EN
            if (flags_clr) sticky_m = '0;
`endif
        end
        if (push) pend.push_back(nr);
        qcnt = qcnt + int'(push) - int'(ret);
        check("in_ready", 64'(in_ready), 64'(qcnt < DEPTH));
        check("out_valid", 64'(out_valid), 64'(slot));
        if (slot) begin
            check("out_result", out_result, slot_item.r);
            check("out_flags", 64'(out_flags), 64'(slot_item.f));
            check("out_denorm", 64'(out_denorm), 64'(slot_item.d));
        end
        check("sticky", 64'(sticky_flags), 64'(sticky_m));
    endtask

    task automatic set_req(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
        in_valid   = 1'b1;
        in_op1     = a;
        in_op2     = b;
        in_rm      = rm;
        in_op_type = OP_ADD;
    endtask

    function automatic logic [63:0] rand_op();
        case ($urandom_range(0, 3))
            0: return TINY;
            1: return ONE;
            2: return $realtobits(real'($urandom_range(0, 1000)) * 0.5);
            default: return $realtobits(real'($urandom_range(0, 1000)));
        endcase
    endfunction

    logic [4:0] exp_nx;

    initial begin
`ifdef FPADD_STICKY_FLAGS_EN
        exp_nx = 5'b00001;
`else
        exp_nx = 5'b00000;
`endif
        model_reset();
        // Reset held with a pending request: nothing may be accepted
        #27;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sticky", 64'(sticky_flags), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        step();

        // Single add, exact
        set_req(ONE, ONE, RM_RD);
        step();
        in_valid = 1'b0;
        step();
        check("add_result", out_result, TWO);
        check("add_flags", 64'(out_flags), 64'd0);
        step();

        // Backpressure: five pushes with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req($realtobits(real'(i + 1)), ONE, RM_RNE);
            step();
        end
        check("bp_full", 64'(in_ready), 64'd0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Sticky inexact persists across a later exact add
        set_req(ONE, TINY, RM_RD);
        step();
        in_valid = 1'b0;
        step();
        check("nx_result", out_result, ONE);
        check("nx_flag", 64'(out_flags[0]), 64'd1);
        check("nx_sticky", 64'(sticky_flags), 64'(exp_nx));
        set_req(TWO, TWO, RM_RD);
        step();
        in_valid = 1'b0;
        step();
        check("nx_persist", 64'(sticky_flags), 64'(exp_nx));

        // Clear on the same edge as an inexact retire
        set_req(ONE, TINY, RM_RD);
        step();
        in_valid  = 1'b0;
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("clr_collide", 64'(sticky_flags), 64'(exp_nx));
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        check("clr_alone", 64'(sticky_flags), 64'd0);

        // Mid-operation reset drops held and queued work
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req($realtobits(real'(i + 10)), TINY, RM_RD);
            step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #3;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_fa_op1", fa_op1, 64'd0);
        reset = 1'b0;
        model_reset();
        out_ready = 1'b1;
        set_req(TWO, ONE, RM_RNE);
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_result", out_result, 64'h4008000000000000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_op1     = rand_op();
            in_op2     = rand_op();
            in_rm      = 3'($urandom_range(0, 7));
            in_op_type = 3'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 3) != 0);
            flags_clr  = ($urandom_range(0, 9) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("drain_empty", 64'(qcnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
